// File: rtl/jtkicker_sdram_sched_if.sv
// Client-side and SDRAM-side signal bundle for jtkicker_sdram_sched.
// master: the game/SDRAM side that drives requests and returns data; slave: the scheduler.
interface jtkicker_sdram_sched_if #(
  parameter int SCR_AW  = 12,
  parameter int OBJ_AW  = 12,
  parameter int MAIN_AW = 15
);
  logic               downloading;
  logic               scr_cs;
  logic [SCR_AW-1:0]  scr_addr;
  logic [15:0]        scr_dout;
  logic               scr_ok;
  logic               obj_cs;
  logic [OBJ_AW-1:0]  obj_addr;
  logic [31:0]        obj_dout;
  logic               obj_ok;
  logic               main_cs;
  logic [MAIN_AW-1:0] main_addr;
  logic [7:0]         main_dout;
  logic               main_ok;
  logic               sdram_req;
  logic [21:0]        sdram_addr;
  logic               sdram_ack;
  logic               data_dst;
  logic               data_rdy;
  logic [15:0]        data_read;

  modport master (
    output downloading, scr_cs, scr_addr, obj_cs, obj_addr, main_cs, main_addr,
           sdram_ack, data_dst, data_rdy, data_read,
    input  scr_dout, scr_ok, obj_dout, obj_ok, main_dout, main_ok, sdram_req, sdram_addr
  );

  modport slave (
    input  downloading, scr_cs, scr_addr, obj_cs, obj_addr, main_cs, main_addr,
           sdram_ack, data_dst, data_rdy, data_read,
    output scr_dout, scr_ok, obj_dout, obj_ok, main_dout, main_ok, sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtkicker_sdram_sched.sv
// Shares one SDRAM read port among scroll (16b), object (32b) and main CPU (8b) ROM clients.
// Define JTKICKER_SCHED_RR_EN for round-robin arbitration; default is fixed main > obj > scr.
module jtkicker_sdram_sched #(
  parameter int          SCR_AW      = 12,
  parameter int          OBJ_AW      = 12,
  parameter int          MAIN_AW     = 15,
  parameter logic [21:0] SCR_OFFSET  = 22'h0,
  parameter logic [21:0] OBJ_OFFSET  = 22'h0,
  parameter logic [21:0] MAIN_OFFSET = 22'h0
)(
  input  logic                   clk,
  input  logic                   rstn,
  jtkicker_sdram_sched_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2} state_t;
  typedef enum logic [1:0] {C_MAIN = 2'd0, C_OBJ = 2'd1, C_SCR = 2'd2} cid_t;

  state_t st_q, st_d;
  cid_t   id_q, id_d, pick;
  logic   pick_vld, grant, rdy;
  logic [21:0] addr_q, addr_d, scr_sa, obj_sa, main_sa;
  logic [15:0] lo_q, lo_d;

  logic [SCR_AW-1:0]  scr_tag_q,  scr_tag_d,  scr_lat_q,  scr_lat_d;
  logic [OBJ_AW-1:0]  obj_tag_q,  obj_tag_d,  obj_lat_q,  obj_lat_d;
  logic [MAIN_AW-2:0] main_tag_q, main_tag_d, main_lat_q, main_lat_d;
  logic [15:0] scr_data_q, scr_data_d, main_data_q, main_data_d;
  logic [31:0] obj_data_q, obj_data_d;
  logic scr_vld_q, scr_vld_d, obj_vld_q, obj_vld_d, main_vld_q, main_vld_d;
  logic scr_hit_d, obj_hit_d, main_hit_d;
  logic scr_ok_q, obj_ok_q, main_ok_q;
  logic [2:0] pend_q, pend_d;  // [0] main, [1] obj, [2] scr
  logic [7:0] main_dout_q, main_dout_d;
  logic unused_dst;

  assign unused_dst = bus.data_dst;
  assign scr_sa  = SCR_OFFSET  + 22'(bus.scr_addr);
  assign obj_sa  = OBJ_OFFSET  + 22'({bus.obj_addr, 1'b0});
  assign main_sa = MAIN_OFFSET + 22'(bus.main_addr[MAIN_AW-1:1]);
  assign grant   = (st_q == IDLE) && !bus.downloading && pick_vld;
  assign rdy     = bus.data_rdy && !bus.downloading;

`ifdef JTKICKER_SCHED_RR_EN
  cid_t last_q;

  // The last served client moves to the back of the rotation main -> obj -> scr.
  always_comb begin
    pick_vld = |pend_q;
    pick     = C_MAIN;
    case (last_q)
      C_MAIN:  pick = pend_q[1] ? C_OBJ  : (pend_q[2] ? C_SCR  : C_MAIN);
      C_OBJ:   pick = pend_q[2] ? C_SCR  : (pend_q[0] ? C_MAIN : C_OBJ);
      default: pick = pend_q[0] ? C_MAIN : (pend_q[1] ? C_OBJ  : C_SCR);
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      last_q <= C_SCR;
    else if (grant) last_q <= pick;
  end
`else
  always_comb begin
    pick_vld = |pend_q;
    pick     = pend_q[0] ? C_MAIN : (pend_q[1] ? C_OBJ : C_SCR);
  end
`endif

  always_comb begin
    st_d        = st_q;
    id_d        = id_q;
    addr_d      = addr_q;
    lo_d        = lo_q;
    scr_lat_d   = scr_lat_q;
    obj_lat_d   = obj_lat_q;
    main_lat_d  = main_lat_q;
    scr_tag_d   = scr_tag_q;
    obj_tag_d   = obj_tag_q;
    main_tag_d  = main_tag_q;
    scr_data_d  = scr_data_q;
    obj_data_d  = obj_data_q;
    main_data_d = main_data_q;
    scr_vld_d   = scr_vld_q;
    obj_vld_d   = obj_vld_q;
    main_vld_d  = main_vld_q;
    case (st_q)
      IDLE: if (grant) begin
        id_d = pick;
        st_d = REQ1;
        case (pick)
          C_MAIN:  begin addr_d = main_sa; main_lat_d = bus.main_addr[MAIN_AW-1:1]; end
          C_OBJ:   begin addr_d = obj_sa;  obj_lat_d  = bus.obj_addr; end
          default: begin addr_d = scr_sa;  scr_lat_d  = bus.scr_addr; end
        endcase
      end
      REQ1: if (bus.sdram_ack) st_d = WAIT1;
      WAIT1: if (rdy) begin
        if (id_q == C_OBJ) begin
          lo_d   = bus.data_read;
          addr_d = addr_q + 22'd1;
          st_d   = REQ2;
        end else begin
          st_d = IDLE;
          if (id_q == C_MAIN) begin
            main_tag_d = main_lat_q; main_data_d = bus.data_read; main_vld_d = 1'b1;
          end else begin
            scr_tag_d = scr_lat_q; scr_data_d = bus.data_read; scr_vld_d = 1'b1;
          end
        end
      end
      REQ2: if (bus.sdram_ack) st_d = WAIT2;
      WAIT2: if (rdy) begin
        obj_tag_d  = obj_lat_q;
        obj_data_d = {bus.data_read, lo_q};
        obj_vld_d  = 1'b1;
        st_d       = IDLE;
      end
      default: st_d = IDLE;
    endcase
    if (bus.downloading) begin
      st_d       = IDLE;
      scr_vld_d  = 1'b0;
      obj_vld_d  = 1'b0;
      main_vld_d = 1'b0;
    end
  end

  // ok and pending are judged against the post-commit entry so a just-filled client is not refetched.
  assign scr_hit_d   = scr_vld_d  && (scr_tag_d  == bus.scr_addr);
  assign obj_hit_d   = obj_vld_d  && (obj_tag_d  == bus.obj_addr);
  assign main_hit_d  = main_vld_d && (main_tag_d == bus.main_addr[MAIN_AW-1:1]);
  assign pend_d      = {bus.scr_cs & ~scr_hit_d, bus.obj_cs & ~obj_hit_d, bus.main_cs & ~main_hit_d};
  assign main_dout_d = bus.main_addr[0] ? main_data_d[15:8] : main_data_d[7:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q        <= IDLE;
      id_q        <= C_MAIN;
      addr_q      <= '0;
      lo_q        <= '0;
      scr_lat_q   <= '0;
      obj_lat_q   <= '0;
      main_lat_q  <= '0;
      scr_tag_q   <= '0;
      obj_tag_q   <= '0;
      main_tag_q  <= '0;
      scr_data_q  <= '0;
      obj_data_q  <= '0;
      main_data_q <= '0;
      scr_vld_q   <= 1'b0;
      obj_vld_q   <= 1'b0;
      main_vld_q  <= 1'b0;
      scr_ok_q    <= 1'b0;
      obj_ok_q    <= 1'b0;
      main_ok_q   <= 1'b0;
      pend_q      <= '0;
      main_dout_q <= '0;
    end else begin
      st_q        <= st_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      lo_q        <= lo_d;
      scr_lat_q   <= scr_lat_d;
      obj_lat_q   <= obj_lat_d;
      main_lat_q  <= main_lat_d;
      scr_tag_q   <= scr_tag_d;
      obj_tag_q   <= obj_tag_d;
      main_tag_q  <= main_tag_d;
      scr_data_q  <= scr_data_d;
      obj_data_q  <= obj_data_d;
      main_data_q <= main_data_d;
      scr_vld_q   <= scr_vld_d;
      obj_vld_q   <= obj_vld_d;
      main_vld_q  <= main_vld_d;
      scr_ok_q    <= bus.scr_cs  & scr_hit_d;
      obj_ok_q    <= bus.obj_cs  & obj_hit_d;
      main_ok_q   <= bus.main_cs & main_hit_d;
      pend_q      <= pend_d;
      main_dout_q <= main_dout_d;
    end
  end

  assign bus.scr_dout   = scr_data_q;
  assign bus.obj_dout   = obj_data_q;
  assign bus.main_dout  = main_dout_q;
  assign bus.scr_ok     = scr_ok_q;
  assign bus.obj_ok     = obj_ok_q;
  assign bus.main_ok    = main_ok_q;
  assign bus.sdram_req  = (st_q == REQ1) || (st_q == REQ2);
  assign bus.sdram_addr = addr_q;
endmodule

// File: tb/tb_jtkicker_sdram_sched.sv
// Directed bench for jtkicker_sdram_sched: expected SDRAM addresses are queued as stimulus
// is applied and popped as the scheduler issues requests; client data is checked against constants.
module tb_jtkicker_sdram_sched;
  localparam logic [21:0] SCR_OFF  = 22'h300000;
  localparam logic [21:0] OBJ_OFF  = 22'h010000;
  localparam logic [21:0] MAIN_OFF = 22'h200000;

  logic clk = 1'b0;
  logic rstn;
  int   errors = 0;
  int   checks = 0;
  logic [21:0] exp_q[$];

  jtkicker_sdram_sched_if #(.SCR_AW(12), .OBJ_AW(12), .MAIN_AW(15)) bus ();

  jtkicker_sdram_sched #(
    .SCR_AW(12), .OBJ_AW(12), .MAIN_AW(15),
    .SCR_OFFSET(SCR_OFF), .OBJ_OFFSET(OBJ_OFF), .MAIN_OFFSET(MAIN_OFF)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for a request, compare against the scoreboard, hold one cycle, then acknowledge.
  task automatic grant();
    int n;
    logic [21:0] e;
    n = 0;
    while (!bus.sdram_req && n < 40) begin
      tick();
      n++;
    end
    chk("req_seen", bus.sdram_req, 1);
    chk("sb_nonempty", (exp_q.size() > 0), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h3fffff;
    chk("sdram_addr", bus.sdram_addr, e);
    tick();
    chk("addr_hold", bus.sdram_addr, e);
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    chk("req_fall", bus.sdram_req, 0);
  endtask

  task automatic rdy(input logic [15:0] d);
    tick();
    bus.data_rdy  = 1'b1;
    bus.data_read = d;
    tick();
    bus.data_rdy  = 1'b0;
  endtask

  initial begin
    rstn            = 1'b0;
    bus.downloading = 1'b0;
    bus.scr_cs      = 1'b0;
    bus.scr_addr    = '0;
    bus.obj_cs      = 1'b0;
    bus.obj_addr    = '0;
    bus.main_cs     = 1'b1;
    bus.main_addr   = 15'h0003;
    bus.sdram_ack   = 1'b0;
    bus.data_dst    = 1'b0;
    bus.data_rdy    = 1'b0;
    bus.data_read   = '0;

    // reset state
    tick(); tick();
    chk("rst_req", bus.sdram_req, 0);
    chk("rst_addr", bus.sdram_addr, 0);
    chk("rst_ok", {bus.scr_ok, bus.obj_ok, bus.main_ok}, 0);
    chk("rst_douts", {bus.main_dout, bus.scr_dout}, 0);
    chk("rst_obj_dout", bus.obj_dout, 0);

    // main byte select and hit
    rstn = 1'b1;
    exp_q.push_back(MAIN_OFF + 22'h1);
    grant();
    rdy(16'hA55A);
    chk("main_ok_hi", bus.main_ok, 1);
    chk("main_dout_hi", bus.main_dout, 8'hA5);
    bus.main_addr = 15'h0002;
    tick();
    chk("main_hit_ok", bus.main_ok, 1);
    chk("main_dout_lo", bus.main_dout, 8'h5A);
    chk("main_hit_noreq", bus.sdram_req, 0);
    tick(); tick();
    chk("main_hit_noreq2", bus.sdram_req, 0);

    // miss latency: two cycles from address change to request
    bus.main_addr = 15'h0100;
    exp_q.push_back(MAIN_OFF + 22'h80);
    tick();
    chk("lat_req_c1", bus.sdram_req, 0);
    chk("lat_ok_c1", bus.main_ok, 0);
    tick();
    chk("lat_req_c2", bus.sdram_req, 1);
    grant();
    rdy(16'h1122);
    chk("main2_dout", bus.main_dout, 8'h22);
    chk("main2_ok", bus.main_ok, 1);

    // cs drop keeps the entry; reassert hits without access
    bus.main_cs = 1'b0;
    tick();
    chk("cs_drop_ok", bus.main_ok, 0);
    tick();
    bus.main_cs = 1'b1;
    tick();
    chk("cs_re_ok", bus.main_ok, 1);
    chk("cs_re_noreq", bus.sdram_req, 0);
    tick();
    chk("cs_re_noreq2", bus.sdram_req, 0);
    bus.main_cs = 1'b0;

    // object: two words assembled low then high
    bus.obj_cs   = 1'b1;
    bus.obj_addr = 12'h010;
    exp_q.push_back(22'h010020);
    exp_q.push_back(22'h010021);
    grant();
    rdy(16'h1234);
    chk("obj_ok_mid", bus.obj_ok, 0);
    grant();
    rdy(16'hABCD);
    chk("obj_ok", bus.obj_ok, 1);
    chk("obj_dout", bus.obj_dout, 32'hABCD1234);
    bus.obj_cs = 1'b0;

    // address change while fetch in flight
    bus.scr_cs   = 1'b1;
    bus.scr_addr = 12'h005;
    exp_q.push_back(SCR_OFF + 22'h5);
    grant();
    bus.scr_addr = 12'h006;
    exp_q.push_back(SCR_OFF + 22'h6);
    rdy(16'h5555);
    chk("scr_chg_ok", bus.scr_ok, 0);
    grant();
    rdy(16'h6666);
    chk("scr_ok", bus.scr_ok, 1);
    chk("scr_dout", bus.scr_dout, 16'h6666);

    // contention; main moves during its fetch so it stays pending
    bus.main_cs   = 1'b1;
    bus.main_addr = 15'h0010;
    bus.obj_cs    = 1'b1;
    bus.obj_addr  = 12'h020;
    bus.scr_addr  = 12'h00A;
    exp_q.push_back(MAIN_OFF + 22'h8);
`ifdef JTKICKER_SCHED_RR_EN
    exp_q.push_back(22'h010040);
    exp_q.push_back(22'h010041);
    exp_q.push_back(SCR_OFF + 22'hA);
    exp_q.push_back(MAIN_OFF + 22'h10);
`else
    exp_q.push_back(MAIN_OFF + 22'h10);
    exp_q.push_back(22'h010040);
    exp_q.push_back(22'h010041);
    exp_q.push_back(SCR_OFF + 22'hA);
`endif
    grant();
    bus.main_addr = 15'h0020;
    rdy(16'h0100);
    for (int i = 1; i < 5; i++) begin
      grant();
      rdy(16'h0100 + 16'(i));
    end
    tick();
    chk("cont_oks", {bus.scr_ok, bus.obj_ok, bus.main_ok}, 3'b111);
`ifdef JTKICKER_SCHED_RR_EN
    chk("cont_main", bus.main_dout, 8'h04);
    chk("cont_obj", bus.obj_dout, 32'h01020101);
    chk("cont_scr", bus.scr_dout, 16'h0103);
`else
    chk("cont_main", bus.main_dout, 8'h01);
    chk("cont_obj", bus.obj_dout, 32'h01030102);
    chk("cont_scr", bus.scr_dout, 16'h0104);
`endif
    tick(); tick();
    chk("cont_idle", bus.sdram_req, 0);
    bus.main_cs = 1'b0;
    bus.obj_cs  = 1'b0;
    bus.scr_cs  = 1'b0;
    tick();

    // download abort during the second object word
    bus.obj_cs   = 1'b1;
    bus.obj_addr = 12'h030;
    bus.scr_cs   = 1'b1;
    exp_q.push_back(22'h010060);
    grant();
    rdy(16'h7777);
    chk("dl_in_req2", bus.sdram_req, 1);
    chk("dl_scr_hit", bus.scr_ok, 1);
    bus.downloading = 1'b1;
    tick();
    chk("dl_req", bus.sdram_req, 0);
    chk("dl_oks", {bus.scr_ok, bus.obj_ok, bus.main_ok}, 0);
    bus.data_rdy  = 1'b1;
    bus.data_read = 16'hDEAD;
    tick();
    bus.data_rdy = 1'b0;
    bus.scr_cs   = 1'b0;
    tick();
    chk("dl_rdy_ignored", bus.obj_ok, 0);
    chk("dl_req2", bus.sdram_req, 0);
    bus.downloading = 1'b0;
    exp_q.push_back(22'h010060);
    exp_q.push_back(22'h010061);
    grant();
    rdy(16'h1111);
    grant();
    rdy(16'h2222);
    chk("dl_obj_ok", bus.obj_ok, 1);
    chk("dl_obj_dout", bus.obj_dout, 32'h22221111);
    bus.scr_cs = 1'b1;
    exp_q.push_back(SCR_OFF + 22'hA);
    grant();
    rdy(16'h3333);
    chk("dl_scr_ok", bus.scr_ok, 1);
    chk("dl_scr_dout", bus.scr_dout, 16'h3333);
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
